// File: rtl/linear_layer_backprop_pkg.sv
// Shared types and helpers for the linear-layer backward pass.
// Optional build macro: LINBP_ROUND_EN selects round-half-up instead of
// floor when a wide accumulator is scaled back to the gradient format.
package linear_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Fixed ceilings so the helpers can serve any reasonable instance size.
  localparam int MAX_FLAT_W = 8192;
  localparam int MAX_W      = 64;
  localparam int MAX_ACC_W  = 160;

  // Accumulator width: full product plus growth for NOUT terms plus a guard bit.
  function automatic int acc_width(input int width, input int nout);
    return 2 * width + $clog2(nout) + 1;
  endfunction

  // Extracts W[r][c]; row r starts at the top of its NIN*WIDTH slice,
  // column 0 in the MSBs. Result is sign-extended to MAX_W bits.
  function automatic logic signed [MAX_W-1:0] get_weight(
    input logic [MAX_FLAT_W-1:0] flat,
    input int r,
    input int c,
    input int nin,
    input int nout,
    input int width
  );
    logic [MAX_W-1:0] raw;
    int lsb;
    lsb = nin * (nout - r) * width - c * width - width;
    raw = MAX_W'(flat >> lsb);
    raw = raw << (MAX_W - width);
    return $signed(raw) >>> (MAX_W - width);
  endfunction

  // Scales the accumulator by 2^-frac and clamps to the signed width range.
  function automatic logic signed [MAX_W-1:0] sat_shift(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int frac,
    input int width
  );
    logic signed [MAX_ACC_W-1:0] v;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    v = acc;
`ifdef LINBP_ROUND_EN
    if (frac > 0) begin
      v = v + (MAX_ACC_W'(1) <<< (frac - 1));
    end else begin
      v = v;
    end
`endif
    v  = v >>> frac;
    hi = (MAX_ACC_W'(1) <<< (width - 1)) - MAX_ACC_W'(1);
    lo = -(MAX_ACC_W'(1) <<< (width - 1));
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end else begin
      v = v;
    end
    return MAX_W'(v);
  endfunction

endpackage

// File: rtl/linear_layer_backprop_mac_accumulator.sv
// Signed multiply-accumulate register. The running sum including the current
// product is exposed combinationally so the caller can consume the final term
// in the same cycle it is added; clear has priority over enable.
module mac_accumulator #(
  parameter int W  = 16,
  parameter int AW = 35
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  output logic signed [AW-1:0] sum
);

  logic signed [2*W-1:0] prod_s;
  logic signed [AW-1:0]  acc_r;

  // Full-precision product sign-extended into the accumulator width.
  always_comb begin
    prod_s = (2*W)'(a) * (2*W)'(b);
    sum    = acc_r + {{(AW-2*W){prod_s[2*W-1]}}, prod_s};
  end

  // Accumulator register: clear wins, otherwise absorb the product when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/linear_layer_backprop.sv
// Backward pass of a linear layer: grad_in = W^T * grad_out, one MAC per cycle,
// column-major over the weight matrix (NIN*NOUT cycles per vector).
// Optional build macro: LINBP_ROUND_EN (round half up before saturation).
module linear_layer_backprop
  import linear_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int NOUT  = 4,
  parameter int FRAC  = 8,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] grad_out [0:NOUT-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] grad_in [0:NIN-1]
);

  localparam int ACC_W = acc_width(WIDTH, NOUT);
  localparam int RW    = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int CW    = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(NOUT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NIN - 1);

  state_e                  state_r;
  logic [RW-1:0]           r_idx_r;
  logic [CW-1:0]           c_idx_r;
  logic signed [WIDTH-1:0] g_r   [0:NOUT-1];
  logic signed [WIDTH-1:0] res_r [0:NIN-1];
  logic signed [WIDTH-1:0] w_s   [0:NOUT-1][0:NIN-1];

  logic                    mac_clr_s;
  logic                    mac_en_s;
  logic signed [WIDTH-1:0] w_sel_s;
  logic signed [WIDTH-1:0] g_sel_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [WIDTH-1:0] res_new_s;

  for (genvar gr = 0; gr < NOUT; gr++) begin : g_row
    for (genvar gc = 0; gc < NIN; gc++) begin : g_col
      assign w_s[gr][gc] = WIDTH'(get_weight(MAX_FLAT_W'(WEIGHTS_MATRIX_FLAT),
                                             gr, gc, NIN, NOUT, WIDTH));
    end
  end

  // MAC control and operand selection; the accumulator restarts after each column.
  always_comb begin
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    w_sel_s   = w_s[r_idx_r][c_idx_r];
    g_sel_s   = g_r[r_idx_r];
    case (state_r)
      IDLE: begin
        mac_clr_s = in_valid && in_ready;
      end
      COMPUTE: begin
        mac_en_s  = 1'b1;
        mac_clr_s = (r_idx_r == R_LAST);
      end
      default: begin
        mac_clr_s = 1'b0;
      end
    endcase
    res_new_s = WIDTH'(sat_shift(MAX_ACC_W'(sum_s), FRAC, WIDTH));
  end

  mac_accumulator #(
    .W  (WIDTH),
    .AW (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr_s),
    .en    (mac_en_s),
    .a     (w_sel_s),
    .b     (g_sel_s),
    .sum   (sum_s)
  );

  // Control FSM with indices and vector registers; grad_in only changes on entry to HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      r_idx_r   <= '0;
      c_idx_r   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int k = 0; k < NOUT; k++) g_r[k] <= '0;
      for (int k = 0; k < NIN; k++) begin
        res_r[k]   <= '0;
        grad_in[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < NOUT; k++) g_r[k] <= grad_out[k];
            r_idx_r  <= '0;
            c_idx_r  <= '0;
            in_ready <= 1'b0;
            state_r  <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (r_idx_r == R_LAST) begin
            res_r[c_idx_r] <= res_new_s;
            r_idx_r        <= '0;
            if (c_idx_r == C_LAST) begin
              c_idx_r   <= '0;
              out_valid <= 1'b1;
              state_r   <= HOLD;
              for (int k = 0; k < NIN; k++) begin
                grad_in[k] <= (CW'(k) == c_idx_r) ? res_new_s : res_r[k];
              end
            end else begin
              c_idx_r <= c_idx_r + CW'(1);
            end
          end else begin
            r_idx_r <= r_idx_r + RW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/linear_layer_backprop.md
Name: linear_layer_backprop

Overview:
Backward-pass counterpart of the combinational linear layer. Accepts an output-gradient vector and computes the input gradient grad_in = W^T * grad_out, using the same flattened weight matrix. Time-multiplexed: one multiply-accumulate per cycle, with valid/ready handshakes on both sides. Sits in the training datapath between the next layer's gradient source and the previous layer's gradient sink.

Parameters:
WIDTH, 16, signed fixed-point bit-width of gradients and weights
NIN, 4, forward input size (length of grad_in)
NOUT, 4, forward output size (length of grad_out)
FRAC, 8, fractional bits; each product is Q(WIDTH-FRAC).FRAC squared
WEIGHTS_MATRIX_FLAT, all zero, WIDTH*NIN*NOUT bits; identical layout to the forward layer

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  grad_out is valid
in_ready  output  1  block can accept grad_out
grad_out  input  signed [WIDTH-1:0] [0:NOUT-1]  output-side gradient vector
out_valid  output  1  grad_in is valid
out_ready  input  1  consumer accepts grad_in
grad_in  output  signed [WIDTH-1:0] [0:NIN-1]  input-side gradient vector

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1 after release; out_valid=0; grad_in all 0; accumulator and indices cleared. Reset asserted mid-compute or mid-hold aborts the transaction with no output.
- Weight W[r][c] = WEIGHTS_MATRIX_FLAT[NIN*(NOUT-r)*WIDTH-1 - c*WIDTH -: WIDTH]; row r maps to forward output r, and the first element of each row sits in the MSBs.
- FSM states: IDLE, COMPUTE, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, register grad_out into an internal vector g, set c=0, r=0, acc=0, and go to COMPUTE.
- COMPUTE: in_ready=0. Each cycle: acc += W[r][c]*g[r]. Products are 2*WIDTH signed; ACC_W = 2*WIDTH+$clog2(NOUT)+1. Then r increments.
  - When r==NOUT-1: grad_in[c] <= sat(acc_final >>> FRAC), where sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Clear acc, set r=0, increment c.
  - When c==NIN-1 and r==NOUT-1: go to HOLD.
  - Row order is c-major, r-minor: exactly NIN*NOUT MAC cycles.
- Latency: out_valid rises on the clock edge exactly NIN*NOUT cycles after the accepting edge (16 for defaults).
- HOLD: out_valid=1. grad_in is stable and all elements update together from the consumer's view; only complete vectors are presented. On out_valid&&out_ready, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
- grad_in holds its last result while IDLE and during the next COMPUTE. Partial writes happen only to internal registers, and the output is copied to grad_in on entry to HOLD.
- No overlap: a new input is never accepted in the same cycle as the output handshake.
- out_ready outside HOLD is ignored. in_valid outside IDLE is ignored (not captured).

Optional Feature:
LINBP_ROUND_EN.
- Defined: add 2^(FRAC-1) to acc before the arithmetic shift (round half up), then saturate.
- Undefined: plain arithmetic shift (floor), then saturate.
- Latency is identical in both cases.

Decomposition:
- Package linear_pkg holds:
  - state enum typedef (IDLE/COMPUTE/HOLD)
  - function acc_width(WIDTH,NOUT)
  - function sat_shift(acc, FRAC, WIDTH) with the rounding macro applied inside
  - function get_weight(flat, r, c, NIN, NOUT, WIDTH)
- One sub-module, mac_accumulator: a signed multiply and accumulate register with clear/enable, async active-low reset.
- The top level owns the FSM, indices and vector registers.

Test Plan:
- Identity (W[i][i]=256, others 0), grad_out=[256,512,-256,0] -> grad_in=[256,512,-256,0]; out_valid exactly 16 cycles after accept.
- Transpose check: only W[0][1]=256, grad_out=[512,0,0,0] -> grad_in=[0,512,0,0] (forward mapping would give [0,0,...] on a different index).
- Saturation: all W=32767, grad_out all 32767 -> all 32767; grad_out all -32768 -> all -32768.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid=1, grad_in stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 next cycle; back-to-back second vector is correct.
- Reset at 5th COMPUTE cycle -> out_valid=0 and grad_in=0 immediately; after release in_ready=1, and the next transaction is correct with a 16-cycle latency.
- Rounding: W[0][0]=1, grad_out=[128,0,0,0] -> grad_in[0]=0 without LINBP_ROUND_EN, 1 with it; grad_out=[-128,...] -> -1 without, 0 with.
